// File: rtl/cut_bist_pkg.sv
// Shared types and helpers for the CUT self-test controller: FSM state
// encoding, CUT bus widths, pattern count and the MISR feedback function.
package cut_bist_pkg;

    localparam int CUT_IN_W  = 3;
    localparam int CUT_OUT_W = 3;
    localparam int N_PAT     = 8;

    // Encoding is also what the dbg_state output reports.
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SETTLE  = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    // One MISR step: s0'=s2^d0, s1'=s0^s2^d1, s2'=s1^d2.
    function automatic logic [CUT_OUT_W-1:0] misr_next(
        input logic [CUT_OUT_W-1:0] s,
        input logic [CUT_OUT_W-1:0] d
    );
        logic [CUT_OUT_W-1:0] n;
        n[0] = s[2] ^ d[0];
        n[1] = s[0] ^ s[2] ^ d[1];
        n[2] = s[1] ^ d[2];
        return n;
    endfunction

endpackage

// File: rtl/cut_bist_misr.sv
// 3-bit multiple-input signature register. Reset and load both put the
// seed into the register; load wins over enable so a new run always starts
// from a known value.
module misr3
    import cut_bist_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load,
    input  logic [CUT_OUT_W-1:0] seed,
    input  logic                 en,
    input  logic [CUT_OUT_W-1:0] d,
    output logic [CUT_OUT_W-1:0] q
);

    // Signature register: seed on reset/load, compress d when enabled, else hold.
    always_ff @(posedge clk) begin
        if (rst || load) begin
            q <= seed;
        end else if (en) begin
            q <= misr_next(q, d);
        end
    end

endmodule

// File: rtl/cut_bist_ctrl.sv
// Self-test controller for a 3-input/3-output combinational CUT. Applies
// patterns 0..7 in order, lets each settle for SETTLE_CYC cycles (1..15),
// compresses the CUT response into a MISR on the capture cycle and compares
// the final signature against golden.
//
// Handshake: start is a request; a run is accepted only on a rising edge of
// start seen while IDLE with abort low, so a start level held through a whole
// run produces exactly one run. abort returns to IDLE from any busy state on
// the next edge, clears pass and freezes the signature. rst beats both.
module cut_bist_ctrl
    import cut_bist_pkg::*;
#(
    parameter int                   SETTLE_CYC = 1,
    parameter logic [CUT_OUT_W-1:0] MISR_SEED  = 3'b000
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 abort,
    input  logic [CUT_OUT_W-1:0] golden,
    output logic [CUT_IN_W-1:0]  cut_in,
    input  logic [CUT_OUT_W-1:0] cut_out,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [CUT_OUT_W-1:0] signature,
    output logic [1:0]           dbg_state
);

    localparam logic [3:0]          SETTLE_LAST = 4'(SETTLE_CYC - 1);
    localparam logic [CUT_IN_W-1:0] PAT_LAST    = CUT_IN_W'(N_PAT - 1);

    state_t              state, state_nxt;
    logic [CUT_IN_W-1:0] pattern, pattern_nxt;
    logic [3:0]          cnt, cnt_nxt;
    logic                pass_r, pass_nxt;
    logic                start_q;
    logic                start_rise;
    logic                misr_load;
    logic                misr_en;

    assign start_rise = start && !start_q;

    // State, pattern, settle counter, pass flag and start history registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            pattern <= '0;
            cnt     <= '0;
            pass_r  <= 1'b0;
            start_q <= 1'b0;
        end else begin
            state   <= state_nxt;
            pattern <= pattern_nxt;
            cnt     <= cnt_nxt;
            pass_r  <= pass_nxt;
            start_q <= start;
        end
    end

    // Next-state logic and MISR control.
    always_comb begin
        state_nxt   = state;
        pattern_nxt = pattern;
        cnt_nxt     = cnt;
        pass_nxt    = pass_r;
        misr_load   = 1'b0;
        misr_en     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start_rise && !abort) begin
                    state_nxt   = ST_SETTLE;
                    pattern_nxt = '0;
                    cnt_nxt     = '0;
                    pass_nxt    = 1'b0;
                    misr_load   = 1'b1;
                end
            end
            ST_SETTLE: begin
                if (abort) begin
                    state_nxt = ST_IDLE;
                    pass_nxt  = 1'b0;
                end else begin
                    cnt_nxt = cnt + 4'd1;
                    if (cnt == SETTLE_LAST) begin
                        state_nxt = ST_CAPTURE;
                    end
                end
            end
            ST_CAPTURE: begin
                if (abort) begin
                    state_nxt = ST_IDLE;
                    pass_nxt  = 1'b0;
                end else begin
                    misr_en = 1'b1;
                    if (pattern == PAT_LAST) begin
                        state_nxt = ST_DONE;
                    end else begin
                        state_nxt   = ST_SETTLE;
                        pattern_nxt = pattern + CUT_IN_W'(1);
                        cnt_nxt     = '0;
                    end
                end
            end
            ST_DONE: begin
                state_nxt = ST_IDLE;
                if (abort) begin
                    pass_nxt = 1'b0;
                end else begin
                    pass_nxt = (signature == golden);
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    misr3 u_misr (
        .clk  (clk),
        .rst  (rst),
        .load (misr_load),
        .seed (MISR_SEED),
        .en   (misr_en),
        .d    (cut_out),
        .q    (signature)
    );

    // Outputs decoded from registered state only.
    assign busy      = (state != ST_IDLE);
    assign done      = (state == ST_DONE);
    assign pass      = pass_r;
    assign cut_in    = ((state == ST_SETTLE) || (state == ST_CAPTURE)) ? pattern : '0;
    assign dbg_state = state;

endmodule

// File: tb/tb_cut_bist_ctrl.sv
// Directed bench for cut_bist_ctrl. A behavioural CUT returns the known-good
// response table; expected signatures and latencies are hand-computed.
module tb_cut_bist_ctrl;

    logic       clk;
    logic       rst;
    logic       start, abort;
    logic [2:0] golden;
    logic [2:0] cut_in, cut_out;
    logic       busy, done, pass;
    logic [2:0] signature;
    logic [1:0] dbg_state;
    logic       force_zero;

    logic       start3;
    logic [2:0] cut_in3, cut_out3;
    logic       busy3, done3, pass3;
    logic [2:0] signature3;
    logic [1:0] dbg_state3;

    int n_checks = 0;
    int n_fail   = 0;

    logic [2:0] exp_q[$];
    logic [2:0] good_trace [8] = '{3'b001, 3'b001, 3'b101, 3'b011,
                                   3'b111, 3'b010, 3'b011, 3'b001};

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Good CUT response per applied pattern.
    function automatic logic [2:0] cut_model(input logic [2:0] p);
        case (p)
            3'd0: return 3'b001;
            3'd1: return 3'b011;
            3'd2: return 3'b111;
            3'd3: return 3'b010;
            3'd4: return 3'b001;
            default: return 3'b111;
        endcase
    endfunction

    assign cut_out  = force_zero ? 3'b000 : cut_model(cut_in);
    assign cut_out3 = cut_model(cut_in3);

    cut_bist_ctrl #(.SETTLE_CYC(1), .MISR_SEED(3'b000)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .golden(golden),
        .cut_in(cut_in), .cut_out(cut_out), .busy(busy), .done(done),
        .pass(pass), .signature(signature), .dbg_state(dbg_state)
    );

    cut_bist_ctrl #(.SETTLE_CYC(3), .MISR_SEED(3'b000)) dut3 (
        .clk(clk), .rst(rst), .start(start3), .abort(1'b0), .golden(3'b001),
        .cut_in(cut_in3), .cut_out(cut_out3), .busy(busy3), .done(done3),
        .pass(pass3), .signature(signature3), .dbg_state(dbg_state3)
    );

    // ---------------- checker ----------------
    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- drivers ----------------
    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic load_trace(input logic zero);
        exp_q.delete();
        for (int i = 0; i < 8; i++) exp_q.push_back(zero ? 3'b000 : good_trace[i]);
    endtask

    // Called at the negedge after the accepting edge (cycle T+1). Checks the
    // MISR after every capture, the pattern on every capture, and returns the
    // cycle number in which done was seen.
    task automatic wait_done(output int lat);
        logic seen;
        logic prev_cap;
        logic [2:0] pat;
        lat = 1; seen = 1'b0; prev_cap = 1'b0; pat = 3'd0;
        while (lat <= 200 && !seen) begin
            if (prev_cap) begin
                if (exp_q.size() > 0) check_eq("misr_trace", signature, exp_q.pop_front());
                else check_eq("trace_underflow", 1, 0);
            end
            prev_cap = (dbg_state == 2'd2);
            if (dbg_state == 2'd2) begin
                check_eq("cap_pattern", cut_in, pat);
                pat = pat + 3'd1;
            end
            if (done) begin
                seen = 1'b1;
                check_eq("cut_in_done", cut_in, 3'b000);
            end else begin
                @(negedge clk);
                lat++;
            end
        end
        if (!seen) check_eq("done_timeout", 0, 1);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int lat, n_done, n_runs, hold0;
        logic prev_busy, found;

        rst = 1'b1; start = 1'b0; abort = 1'b0; golden = 3'b001;
        force_zero = 1'b0; start3 = 1'b0;
        repeat (2) @(negedge clk);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_done", done, 0);
        check_eq("rst_pass", pass, 0);
        check_eq("rst_cut_in", cut_in, 0);
        check_eq("rst_sig", signature, 3'b000);
        check_eq("rst_state", dbg_state, 0);
        rst = 1'b0;

        // Good run, SETTLE_CYC=1.
        load_trace(1'b0);
        pulse_start();
        wait_done(lat);
        check_eq("good_latency", lat, 17);
        check_eq("good_sig", signature, 3'b001);
        @(negedge clk);
        check_eq("good_done_one_cycle", done, 0);
        check_eq("good_idle", busy, 0);
        check_eq("good_pass", pass, 1);
        check_eq("good_sig_hold", signature, 3'b001);

        // Stuck-at-zero CUT outputs.
        force_zero = 1'b1;
        load_trace(1'b1);
        pulse_start();
        check_eq("zero_pass_cleared", pass, 0);
        wait_done(lat);
        check_eq("zero_latency", lat, 17);
        @(negedge clk);
        check_eq("zero_sig", signature, 3'b000);
        check_eq("zero_pass", pass, 0);
        force_zero = 1'b0;

        // Good run to set pass, then abort during pattern 4 SETTLE.
        load_trace(1'b0);
        pulse_start();
        wait_done(lat);
        @(negedge clk);
        check_eq("pre_abort_pass", pass, 1);
        pulse_start();
        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            if (dbg_state == 2'd1 && cut_in == 3'd4) found = 1'b1;
            else @(negedge clk);
        end
        check_eq("abort_reach_pat4", found, 1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check_eq("abort_busy", busy, 0);
        check_eq("abort_done", done, 0);
        check_eq("abort_pass", pass, 0);
        check_eq("abort_sig_held", signature, 3'b011);
        n_done = 0;
        repeat (20) begin
            @(negedge clk);
            if (done) n_done++;
        end
        check_eq("abort_no_done", n_done, 0);
        load_trace(1'b0);
        pulse_start();
        wait_done(lat);
        check_eq("rerun_latency", lat, 17);
        @(negedge clk);
        check_eq("rerun_pass", pass, 1);

        // start and abort together in IDLE: abort wins.
        @(negedge clk);
        start = 1'b1; abort = 1'b1;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        check_eq("start_abort_idle", busy, 0);
        check_eq("start_abort_pass", pass, 1);

        // start held high for a long time: one run, one done pulse.
        @(negedge clk);
        start = 1'b1;
        n_done = 0; n_runs = 0; prev_busy = 1'b0;
        repeat (60) begin
            @(negedge clk);
            if (done) n_done++;
            if (busy && !prev_busy) n_runs++;
            prev_busy = busy;
        end
        start = 1'b0;
        check_eq("held_start_runs", n_runs, 1);
        check_eq("held_start_done", n_done, 1);
        check_eq("held_start_pass", pass, 1);

        // Reset asserted during CAPTURE.
        pulse_start();
        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            if (dbg_state == 2'd2 && cut_in == 3'd2) found = 1'b1;
            else @(negedge clk);
        end
        check_eq("rst_reach_capture", found, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_eq("midrst_busy", busy, 0);
        check_eq("midrst_done", done, 0);
        check_eq("midrst_pass", pass, 0);
        check_eq("midrst_cut_in", cut_in, 0);
        check_eq("midrst_sig", signature, 3'b000);
        check_eq("midrst_state", dbg_state, 0);
        n_done = 0;
        repeat (30) begin
            @(negedge clk);
            if (done) n_done++;
        end
        check_eq("midrst_no_done", n_done, 0);

        // SETTLE_CYC=3 instance: 4 cycles per pattern, done at T+33.
        @(negedge clk);
        start3 = 1'b1;
        @(negedge clk);
        start3 = 1'b0;
        lat = 1; hold0 = 0; found = 1'b0;
        while (lat <= 200 && !found) begin
            if (busy3 && !done3 && cut_in3 == 3'd0) hold0++;
            if (done3) found = 1'b1;
            else begin
                @(negedge clk);
                lat++;
            end
        end
        check_eq("s3_done_seen", found, 1);
        check_eq("s3_latency", lat, 33);
        check_eq("s3_pat0_hold", hold0, 4);
        check_eq("s3_sig", signature3, 3'b001);
        @(negedge clk);
        check_eq("s3_pass", pass3, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
